// File: rtl/mem_access_stage_pkg.sv
// Shared general definitions: widths, write-back control encodings and memory-stage enums.
package mem_access_stage_pkg;
  localparam int ADDR_WIDTH = 5;
  localparam int WORD       = 32;

  typedef enum logic [1:0] {
    FROM_ALU = 2'd0,
    FROM_MEM = 2'd1,
    FROM_PC  = 2'd2
  } reg_file_data_source;

  typedef enum logic {
    WRITE_DIS = 1'b0,
    WRITE_EN  = 1'b1
  } reg_file_write_sig;

  typedef enum logic {
    NO_BRANCH = 1'b0,
    BRANCH    = 1'b1
  } branch_from_wb;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_t;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } mem_state_t;
endpackage

// File: rtl/dmem_timeout_counter.sv
// Watchdog for an outstanding data-memory access; timeout_o is high once LIMIT
// unacknowledged wait cycles have been counted.
module dmem_timeout_counter #(
  parameter int LIMIT = 64
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic timeout_o
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_count;

  assign timeout_o = (r_count == CW'(LIMIT));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_count <= '0;
    end else if (clr_i || timeout_o) begin
      r_count <= '0;
    end else if (inc_i) begin
      r_count <= r_count + 1'b1;
    end
  end
endmodule

// File: rtl/mem_access_stage.sv
// Memory access stage: issues loads/stores over req/ack, stalls upstream while waiting,
// and fills the MEM/WB register. Optional watchdog enabled by DMEM_TIMEOUT_EN.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DMEM_TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  is_valid_i,
  input  mem_op_t               mem_op_i,
  input  reg_file_data_source   reg_data_ctrl_sig_i,
  input  reg_file_write_sig     reg_file_write_en_i,
  input  branch_from_wb         branch_from_wb_i,
  input  logic [ADDR_WIDTH-1:0] reg_dest_addr_i,
  input  logic [WORD-1:0]       alu_result_i,
  input  logic [WORD-1:0]       store_data_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [WORD-1:0]       dmem_addr_o,
  output logic [WORD-1:0]       dmem_wdata_o,
  input  logic [WORD-1:0]       dmem_rdata_i,
  input  logic                  dmem_ack_i,
  output logic                  is_valid_o,
  output reg_file_data_source   reg_data_ctrl_sig_o,
  output reg_file_write_sig     reg_file_write_en_o,
  output branch_from_wb         branch_from_wb_o,
  output logic [ADDR_WIDTH-1:0] reg_dest_addr_o,
  output logic [WORD-1:0]       alu_result_o,
  output logic [WORD-1:0]       mem_data_o,
  output logic                  fault_o,
  output mem_state_t            dbg_state_o
);
  // Handshake: a transfer completes in the cycle where dmem_req_o and dmem_ack_i are both
  // high; while req is high without ack, upstream holds every input stable (stall_o).

  mem_state_t r_state;
  logic       r_killed;
  logic       w_is_mem;
  logic       w_issue;
  logic       w_ack;
  logic       w_capture;
  logic       w_timeout;

  assign w_is_mem     = is_valid_i && (mem_op_i != MEM_NONE);
  assign w_issue      = (r_state == IDLE) && w_is_mem && !flush_i;
  assign dmem_req_o   = w_issue || ((r_state == WAIT_ACK) && !w_timeout);
  assign dmem_we_o    = dmem_req_o && (mem_op_i == MEM_STORE);
  assign dmem_addr_o  = alu_result_i;
  assign dmem_wdata_o = store_data_i;
  assign w_ack        = dmem_req_o && dmem_ack_i;
  assign stall_o      = dmem_req_o && !dmem_ack_i;
  assign dbg_state_o  = r_state;

  // A killed access still completes on the bus but must not reach write-back.
  assign w_capture = (w_ack && !flush_i && !r_killed) ||
                     ((r_state == IDLE) && is_valid_i && (mem_op_i == MEM_NONE) && !flush_i);

`ifdef DMEM_TIMEOUT_EN
  logic r_fault;

  dmem_timeout_counter #(
    .LIMIT(DMEM_TIMEOUT_CYCLES)
  ) u_dmem_timeout_counter (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .inc_i     ((r_state == WAIT_ACK) && !dmem_ack_i),
    .clr_i     ((r_state != WAIT_ACK) || dmem_ack_i),
    .timeout_o (w_timeout)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_fault <= 1'b0;
    end else begin
      r_fault <= w_timeout;
    end
  end

  assign fault_o = r_fault;
`else
  logic [31:0] w_unused_timeout_cycles;

  assign w_unused_timeout_cycles = DMEM_TIMEOUT_CYCLES;
  assign w_timeout               = 1'b0;
  assign fault_o                 = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= IDLE;
      r_killed <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_killed <= 1'b0;
          if (w_issue && !dmem_ack_i) begin
            r_state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (dmem_ack_i || w_timeout) begin
            r_state  <= IDLE;
            r_killed <= 1'b0;
          end else if (flush_i) begin
            r_killed <= 1'b1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_killed <= 1'b0;
        end
      endcase
    end
  end

  // MEM/WB register: loads the instruction when captured, otherwise a full bubble.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      is_valid_o          <= 1'b0;
      reg_data_ctrl_sig_o <= FROM_ALU;
      reg_file_write_en_o <= WRITE_DIS;
      branch_from_wb_o    <= NO_BRANCH;
      reg_dest_addr_o     <= '0;
      alu_result_o        <= '0;
      mem_data_o          <= '0;
    end else if (w_capture) begin
      is_valid_o          <= 1'b1;
      reg_data_ctrl_sig_o <= reg_data_ctrl_sig_i;
      reg_file_write_en_o <= reg_file_write_en_i;
      branch_from_wb_o    <= branch_from_wb_i;
      reg_dest_addr_o     <= reg_dest_addr_i;
      alu_result_o        <= alu_result_i;
      mem_data_o          <= (mem_op_i == MEM_LOAD) ? dmem_rdata_i : '0;
    end else begin
      is_valid_o          <= 1'b0;
      reg_data_ctrl_sig_o <= FROM_ALU;
      reg_file_write_en_o <= WRITE_DIS;
      branch_from_wb_o    <= NO_BRANCH;
      reg_dest_addr_o     <= '0;
      alu_result_o        <= '0;
      mem_data_o          <= '0;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: single-cycle vector table plus
// directed multi-cycle sequences (wait states, flush, reset, optional timeout).
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic                  is_valid_i;
  mem_op_t               mem_op_i;
  reg_file_data_source   src_i;
  reg_file_write_sig     wen_i;
  branch_from_wb         br_i;
  logic [ADDR_WIDTH-1:0] rd_i;
  logic [WORD-1:0]       alu_i;
  logic [WORD-1:0]       sdata_i;
  logic                  flush_i;
  logic                  stall_o;
  logic                  req_o;
  logic                  we_o;
  logic [WORD-1:0]       addr_o;
  logic [WORD-1:0]       wdata_o;
  logic [WORD-1:0]       rdata_i;
  logic                  ack_i;
  logic                  valid_o;
  reg_file_data_source   src_o;
  reg_file_write_sig     wen_o;
  branch_from_wb         br_o;
  logic [ADDR_WIDTH-1:0] rd_o;
  logic [WORD-1:0]       alu_o;
  logic [WORD-1:0]       mem_o;
  logic                  fault_o;
  mem_state_t            state_o;

  int n_checks;
  int n_fail;

  mem_access_stage #(.DMEM_TIMEOUT_CYCLES(4)) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .is_valid_i          (is_valid_i),
    .mem_op_i            (mem_op_i),
    .reg_data_ctrl_sig_i (src_i),
    .reg_file_write_en_i (wen_i),
    .branch_from_wb_i    (br_i),
    .reg_dest_addr_i     (rd_i),
    .alu_result_i        (alu_i),
    .store_data_i        (sdata_i),
    .flush_i             (flush_i),
    .stall_o             (stall_o),
    .dmem_req_o          (req_o),
    .dmem_we_o           (we_o),
    .dmem_addr_o         (addr_o),
    .dmem_wdata_o        (wdata_o),
    .dmem_rdata_i        (rdata_i),
    .dmem_ack_i          (ack_i),
    .is_valid_o          (valid_o),
    .reg_data_ctrl_sig_o (src_o),
    .reg_file_write_en_o (wen_o),
    .branch_from_wb_o    (br_o),
    .reg_dest_addr_o     (rd_o),
    .alu_result_o        (alu_o),
    .mem_data_o          (mem_o),
    .fault_o             (fault_o),
    .dbg_state_o         (state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                valid;
    mem_op_t             op;
    reg_file_data_source src;
    reg_file_write_sig   wen;
    branch_from_wb       br;
    logic [4:0]          rd;
    logic [31:0]         alu;
    logic [31:0]         sdata;
    logic                flush;
    logic                ack;
    logic [31:0]         rdata;
    logic                e_req;
    logic                e_we;
    logic                e_stall;
    logic                e_valid;
    logic [31:0]         e_mem;
    logic [31:0]         e_alu;
    logic [4:0]          e_rd;
    logic                e_wen;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input mem_op_t op, input reg_file_data_source s,
                        input reg_file_write_sig w, input branch_from_wb b, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] sd);
    is_valid_i = v;
    mem_op_i   = op;
    src_i      = s;
    wen_i      = w;
    br_i       = b;
    rd_i       = rd;
    alu_i      = alu;
    sdata_i    = sd;
  endtask

  task automatic idle_in();
    set_in(1'b0, MEM_NONE, FROM_ALU, WRITE_DIS, NO_BRANCH, 5'd0, 32'd0, 32'd0);
    flush_i = 1'b0;
    ack_i   = 1'b0;
    rdata_i = 32'd0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle_in();

    //                valid op         src       wen        br         rd     alu           sdata  fl ack rdata          req we st val mem           alu           rd     wen
    vecs[0] = '{1'b1, MEM_LOAD,  FROM_MEM, WRITE_EN,  NO_BRANCH, 5'd5,  32'h100, 32'h0,  1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h100, 5'd5,  1'b1};
    vecs[1] = '{1'b1, MEM_NONE,  FROM_ALU, WRITE_EN,  NO_BRANCH, 5'd3,  32'h7,   32'h0,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h7,   5'd3,  1'b1};
    vecs[2] = '{1'b1, MEM_STORE, FROM_ALU, WRITE_DIS, NO_BRANCH, 5'd0,  32'h40,  32'h55, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,        32'h40,  5'd0,  1'b0};
    vecs[3] = '{1'b0, MEM_LOAD,  FROM_MEM, WRITE_EN,  NO_BRANCH, 5'd9,  32'h80,  32'h0,  1'b0, 1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,   5'd0,  1'b0};
    vecs[4] = '{1'b1, MEM_LOAD,  FROM_MEM, WRITE_EN,  NO_BRANCH, 5'd9,  32'h80,  32'h0,  1'b1, 1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,   5'd0,  1'b0};
    vecs[5] = '{1'b1, MEM_NONE,  FROM_ALU, WRITE_EN,  NO_BRANCH, 5'd4,  32'h99,  32'h0,  1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,   5'd0,  1'b0};
    vecs[6] = '{1'b1, MEM_LOAD,  FROM_MEM, WRITE_EN,  NO_BRANCH, 5'd31, 32'h200, 32'h0,  1'b0, 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b1, 32'h12345678, 32'h200, 5'd31, 1'b1};

    // Reset values
    step();
    step();
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_src", src_o, FROM_ALU);
    chk("rst_wen", wen_o, WRITE_DIS);
    chk("rst_br", br_o, NO_BRANCH);
    chk("rst_rd", rd_o, 5'd0);
    chk("rst_alu", alu_o, 32'd0);
    chk("rst_mem", mem_o, 32'd0);
    chk("rst_fault", fault_o, 1'b0);
    chk("rst_req", req_o, 1'b0);
    chk("rst_state", state_o, IDLE);
    rst_n = 1'b1;
    step();

    // Single-cycle vector table
    for (int i = 0; i < 7; i++) begin
      set_in(vecs[i].valid, vecs[i].op, vecs[i].src, vecs[i].wen, vecs[i].br, vecs[i].rd,
             vecs[i].alu, vecs[i].sdata);
      flush_i = vecs[i].flush;
      ack_i   = vecs[i].ack;
      rdata_i = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_req", i), req_o, vecs[i].e_req);
      chk($sformatf("v%0d_we", i), we_o, vecs[i].e_we);
      chk($sformatf("v%0d_stall", i), stall_o, vecs[i].e_stall);
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_addr", i), addr_o, vecs[i].alu);
        chk($sformatf("v%0d_wdata", i), wdata_o, vecs[i].sdata);
      end
      step();
      idle_in();
      chk($sformatf("v%0d_valid", i), valid_o, vecs[i].e_valid);
      chk($sformatf("v%0d_mem", i), mem_o, vecs[i].e_mem);
      chk($sformatf("v%0d_alu", i), alu_o, vecs[i].e_alu);
      chk($sformatf("v%0d_rd", i), rd_o, vecs[i].e_rd);
      chk($sformatf("v%0d_wen", i), wen_o, vecs[i].e_wen);
      chk($sformatf("v%0d_state", i), state_o, IDLE);
    end

    // Store with 3 wait states
    set_in(1'b1, MEM_STORE, FROM_ALU, WRITE_DIS, NO_BRANCH, 5'd0, 32'h40, 32'h55);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("st_w%0d_stall", c), stall_o, 1'b1);
      chk($sformatf("st_w%0d_we", c), we_o, 1'b1);
      chk($sformatf("st_w%0d_addr", c), addr_o, 32'h40);
      step();
      chk($sformatf("st_w%0d_bubble", c), valid_o, 1'b0);
      chk($sformatf("st_w%0d_state", c), state_o, WAIT_ACK);
    end
    ack_i = 1'b1;
    #1;
    chk("st_ack_stall", stall_o, 1'b0);
    chk("st_ack_we", we_o, 1'b1);
    step();
    idle_in();
    chk("st_valid", valid_o, 1'b1);
    chk("st_mem", mem_o, 32'h0);
    chk("st_state", state_o, IDLE);

    // Load stalled 2 cycles, flush pulsed while waiting
    set_in(1'b1, MEM_LOAD, FROM_MEM, WRITE_EN, NO_BRANCH, 5'd7, 32'h300, 32'h0);
    #1;
    chk("fl_c0_req", req_o, 1'b1);
    step();
    flush_i = 1'b1;
    #1;
    chk("fl_c1_req", req_o, 1'b1);
    step();
    flush_i = 1'b0;
    ack_i   = 1'b1;
    rdata_i = 32'hCAFEF00D;
    #1;
    chk("fl_c2_req", req_o, 1'b1);
    chk("fl_c2_stall", stall_o, 1'b0);
    step();
    idle_in();
    chk("fl_valid", valid_o, 1'b0);
    chk("fl_wen", wen_o, WRITE_DIS);
    chk("fl_mem", mem_o, 32'h0);
    chk("fl_state", state_o, IDLE);

    // POP-to-PC load with one wait state
    set_in(1'b1, MEM_LOAD, FROM_MEM, WRITE_DIS, BRANCH, 5'd0, 32'h1F0, 32'h0);
    #1;
    chk("pc_c0_stall", stall_o, 1'b1);
    step();
    ack_i   = 1'b1;
    rdata_i = 32'h00000400;
    step();
    idle_in();
    chk("pc_valid", valid_o, 1'b1);
    chk("pc_br", br_o, BRANCH);
    chk("pc_mem", mem_o, 32'h00000400);
    chk("pc_src", src_o, FROM_MEM);

    // Flush in the same cycle as the ack
    set_in(1'b1, MEM_LOAD, FROM_MEM, WRITE_EN, NO_BRANCH, 5'd2, 32'h44, 32'h0);
    step();
    flush_i = 1'b1;
    ack_i   = 1'b1;
    rdata_i = 32'h0BADBEEF;
    step();
    idle_in();
    chk("flack_valid", valid_o, 1'b0);
    chk("flack_state", state_o, IDLE);

    // Reset mid-access; a later ack is ignored
    set_in(1'b1, MEM_LOAD, FROM_MEM, WRITE_EN, NO_BRANCH, 5'd6, 32'h88, 32'h0);
    step();
    chk("rm_wait", state_o, WAIT_ACK);
    is_valid_i = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("rm_state", state_o, IDLE);
    chk("rm_req", req_o, 1'b0);
    rst_n   = 1'b1;
    ack_i   = 1'b1;
    rdata_i = 32'h77777777;
    step();
    idle_in();
    chk("rm_valid", valid_o, 1'b0);
    chk("rm_mem", mem_o, 32'h0);
    chk("rm_state2", state_o, IDLE);

`ifdef DMEM_TIMEOUT_EN
    // Ack never arrives: watchdog fires after 4 waiting cycles
    set_in(1'b1, MEM_LOAD, FROM_MEM, WRITE_EN, NO_BRANCH, 5'd1, 32'h500, 32'h0);
    step();
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("to_w%0d_stall", c), stall_o, 1'b1);
      chk($sformatf("to_w%0d_fault", c), fault_o, 1'b0);
      step();
    end
    #1;
    chk("to_req_drop", req_o, 1'b0);
    chk("to_stall_drop", stall_o, 1'b0);
    step();
    idle_in();
    chk("to_fault", fault_o, 1'b1);
    chk("to_state", state_o, IDLE);
    chk("to_bubble", valid_o, 1'b0);
    step();
    chk("to_fault_pulse", fault_o, 1'b0);
`else
    // Without the watchdog, a long wait never faults
    set_in(1'b1, MEM_LOAD, FROM_MEM, WRITE_EN, NO_BRANCH, 5'd1, 32'h500, 32'h0);
    for (int c = 0; c < 8; c++) step();
    #1;
    chk("nt_stall", stall_o, 1'b1);
    chk("nt_fault", fault_o, 1'b0);
    chk("nt_state", state_o, WAIT_ACK);
    ack_i = 1'b1;
    step();
    idle_in();
    chk("nt_valid", valid_o, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline stage between execute and write-back. It issues data-memory loads and stores over a request/acknowledge interface and stalls upstream while a variable-latency access is outstanding. It registers the result, control and destination fields into the MEM/WB pipeline register that write-back consumes, and discards accesses squashed by a flush.

## Interface
Parameters:
- ADDR_WIDTH, from the shared package: register-file address width.
- WORD, from the shared package: data word width (32).
- DMEM_TIMEOUT_CYCLES, default 64: watchdog limit. Used only when DMEM_TIMEOUT_EN is defined.

Ports:
- clk_i  in  1  clock. One clock domain.
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- is_valid_i  in  1  execute-stage slot holds a real instruction.
- mem_op_i  in  mem_op_t  MEM_NONE / MEM_LOAD / MEM_STORE.
- reg_data_ctrl_sig_i  in  reg_file_data_source  write-back data select.
- reg_file_write_en_i  in  reg_file_write_sig  register write enable.
- branch_from_wb_i  in  branch_from_wb  loaded word is the new PC.
- reg_dest_addr_i  in  ADDR_WIDTH  destination register.
- alu_result_i  in  WORD  ALU result; also the memory address.
- store_data_i  in  WORD  store data.
- flush_i  in  1  squash the instruction currently in this stage.
- stall_o  out  1  upstream must hold its inputs stable.
- dmem_req_o, dmem_we_o  out  1  request and write strobe.
- dmem_addr_o, dmem_wdata_o  out  WORD  address and write data.
- dmem_rdata_i  in  WORD  read data, valid with ack.
- dmem_ack_i  in  1  access complete.
- is_valid_o, reg_data_ctrl_sig_o, reg_file_write_en_o, branch_from_wb_o, reg_dest_addr_o, alu_result_o, mem_data_o  out  MEM/WB register fields.
- fault_o  out  1  one-cycle pulse on memory timeout.

## Operation
- States: IDLE and WAIT_ACK.
- **IDLE**
  - A valid memory op with flush_i low drives the memory interface combinationally: dmem_req_o=1, dmem_we_o=(op==MEM_STORE), dmem_addr_o=alu_result_i, dmem_wdata_o=store_data_i.
  - dmem_ack_i high in the same cycle: MEM/WB captures the instruction at the edge and the state stays IDLE.
  - dmem_ack_i low: stall_o=1 and the state moves to WAIT_ACK.
  - A valid MEM_NONE instruction passes through into MEM/WB in 1 cycle.
- **WAIT_ACK**
  - dmem_req_o stays high and the address and data stay stable; upstream holds them.
  - On ack, MEM/WB captures the result, stall_o=0 that cycle, and the state returns to IDLE.
- stall_o = dmem_req_o & ~dmem_ack_i, combinational.
- Capture values:
  - mem_data_o = dmem_rdata_i for loads, 0 for stores and MEM_NONE.
  - All other fields are copied from the inputs.
- Whenever this stage does not capture an instruction, MEM/WB loads a bubble: is_valid_o=0. This covers a stall cycle, invalid input and a flush.
- Flush:
  - In IDLE: no request is issued and a bubble is loaded.
  - In WAIT_ACK: the bus access is not aborted. A killed flag is set, the access completes, and on ack a bubble is loaded instead of the result.
  - A flush in the same cycle as the ack also yields a bubble.

## Timing
- MEM_NONE: 1 cycle. Memory op: 1 + N cycles for N wait states.
- MEM/WB updates on every rising clk_i edge; there is no enable.
- Reset values:
  - State IDLE, killed flag 0, timeout counter 0.
  - is_valid_o=0, reg_data_ctrl_sig_o=FROM_ALU, reg_file_write_en_o and branch_from_wb_o deasserted.
  - reg_dest_addr_o, alu_result_o and mem_data_o = 0; fault_o=0.
  - dmem_req_o=0.
- Reset asserted mid-access returns the block to IDLE immediately; an ack arriving after reset is ignored.

## Configuration
- DMEM_TIMEOUT_EN defined:
  - A counter increments each WAIT_ACK cycle without ack.
  - When the counter reaches DMEM_TIMEOUT_CYCLES, dmem_req_o drops, fault_o pulses for 1 cycle, a bubble is loaded, the state returns to IDLE and the counter clears.
  - The counter clears on every ack.
- DMEM_TIMEOUT_EN undefined: the counter is absent, WAIT_ACK waits indefinitely, and fault_o is tied to 0.

## Structure
- The shared package (GENERAL_DEFS) gains mem_op_t {MEM_NONE, MEM_LOAD, MEM_STORE} and mem_state_t {IDLE, WAIT_ACK}.
- The existing reg_file_data_source, reg_file_write_sig, branch_from_wb, WORD and ADDR_WIDTH come from the same package.
- One sub-module, dmem_timeout_counter, holds the watchdog and is instantiated only under DMEM_TIMEOUT_EN.

## Test plan
- Load to 0x100 with ack in the same cycle, rdata 0xDEADBEEF: no stall; next cycle is_valid_o=1 and mem_data_o=0xDEADBEEF.
- Store 0x55 to 0x40 with ack after 3 wait states: stall_o high for 3 cycles with 3 bubbles, dmem_we_o=1 throughout, then is_valid_o=1 and mem_data_o=0.
- ALU op with alu_result_i=7 and rd=3: 1 cycle later alu_result_o=7, reg_dest_addr_o=3, dmem_req_o never asserted.
- Load stalled 2 cycles with flush_i pulsed in WAIT_ACK: the request is held until ack, then a bubble with is_valid_o=0 and no register write.
- POP-to-PC load, ack 1 wait state later: branch_from_wb_o=1 and mem_data_o equals the loaded PC.
- DMEM_TIMEOUT_EN with DMEM_TIMEOUT_CYCLES=4 and ack never asserted: fault_o pulses once after 4 WAIT_ACK cycles, the state returns to IDLE and stall_o drops.
